// File: rtl/sha1_pkg.sv
// Shared SHA1 definitions: block geometry, round constants, state encoding
// and the rotate helper used by the message schedule.
package sha1_pkg;

    localparam int SHA1_N               = 32;
    localparam int SHA1_WORDS_PER_BLOCK = 16;
    localparam int SHA1_ROUNDS          = 80;
    localparam int SHA1_BLOCK_W         = 512;

    // Round constants, one per group of 20 rounds; consumed by the round stage.
    localparam logic [31:0] SHA1_K0 = 32'h5A827999;
    localparam logic [31:0] SHA1_K1 = 32'h6ED9EBA1;
    localparam logic [31:0] SHA1_K2 = 32'h8F1BBCDC;
    localparam logic [31:0] SHA1_K3 = 32'hCA62C1D6;

    typedef logic [0:0] sha1_state_t;
    localparam sha1_state_t ST_IDLE = 1'b0;
    localparam sha1_state_t ST_RUN  = 1'b1;

    function automatic logic [SHA1_N-1:0] rotl1(input logic [SHA1_N-1:0] x);
        return {x[SHA1_N-2:0], x[SHA1_N-1]};
    endfunction

endpackage

// File: rtl/sha1_w_window.sv
// 16-word sliding window of the SHA1 schedule: parallel load of a block,
// shift-down by one word per step with the ROTL1 recurrence fed into the top.
module sha1_w_window
    import sha1_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    shift,
    input  logic [SHA1_BLOCK_W-1:0] block_in,
    output logic [SHA1_N-1:0]       w
);

    logic [SHA1_N-1:0] win [SHA1_WORDS_PER_BLOCK];
    logic [SHA1_N-1:0] mix;

    // win[i] holds W[t+i], so W[t+16] draws from taps 13, 8, 2 and 0.
    assign mix = win[13] ^ win[8] ^ win[2] ^ win[0];
    assign w   = win[0];

    always_ff @(posedge clk) begin
        // NOTE: the window is cleared on reset so w reads zero until the first
        // load; this storage is small enough that a reset costs nothing notable.
        if (rst) begin
            for (int i = 0; i < SHA1_WORDS_PER_BLOCK; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < SHA1_WORDS_PER_BLOCK; i++)
                win[i] <= block_in[SHA1_BLOCK_W-1-SHA1_N*i -: SHA1_N];
        end else if (shift) begin
            for (int i = 0; i < SHA1_WORDS_PER_BLOCK - 1; i++) win[i] <= win[i+1];
            win[SHA1_WORDS_PER_BLOCK-1] <= rotl1(mix);
        end
    end

endmodule

// File: rtl/sha1_msg_sched.sv
// SHA1 message schedule generator: accepts one padded 512-bit block and
// streams W[0..79] with a 1-based round index under valid/ready flow control.
module sha1_msg_sched
    import sha1_pkg::*;
#(
    parameter int N      = 32,
    parameter int ROUNDS = 80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [16*N-1:0] block_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  w,
    output logic [7:0]    round,
    output logic          last,
    output logic          busy
);

    sha1_state_t state;
    logic        load;
    logic        fire;

    // Handshake outputs decode from registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_RUN);
    assign busy      = out_valid;
    assign last      = out_valid && (round == 8'(ROUNDS));

    assign load = in_valid && in_ready;
    assign fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            round <= 8'd0;
        end else if (state == ST_IDLE) begin
            if (load) begin
                state <= ST_RUN;
                round <= 8'd1;
            end
        end else if (fire) begin
            if (last) begin
                state <= ST_IDLE;
                round <= 8'd0;
            end else begin
                round <= round + 8'd1;
            end
        end
    end

    sha1_w_window u_window (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (fire && !last),
        .block_in (block_in),
        .w        (w)
    );

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Directed bench for sha1_msg_sched: reset, the "abc" block, backpressure,
// back-to-back blocks, ignored in_valid, mid-block reset and all-ones.
module tb_sha1_msg_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] block_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  w;
    logic [7:0]   round;
    logic         last;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_w [80];
    logic [31:0] got_w [80];

    sha1_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w         (w),
        .round     (round),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference schedule in its textbook form: W[t] = ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
    function automatic void build_exp(input logic [511:0] blk);
        logic [31:0] x;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x = exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16];
            exp_w[t] = {x[30:0], x[31]};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents blk for one accepting edge; caller must be idle at #1 after an edge.
    task automatic start_block(input logic [511:0] blk);
        build_exp(blk);
        in_valid = 1'b1;
        block_in = blk;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || round !== 8'd1) begin
            failures++;
            $display("FAIL start: out_valid=%b round=%0d expected 1/1", out_valid, round);
        end
    endtask

    // Consumes n_words schedule words, stalling with probability bp_pct percent.
    task automatic drain(input int n_words, input int bp_pct, output int fires);
        int          idx = 0;
        int          guard = 0;
        logic        stalled = 1'b0;
        logic [31:0] hold_w = '0;
        logic [7:0]  hold_r = '0;
        while (idx < n_words && guard < 4000) begin
            if (stalled) begin
                checks++;
                if (w !== hold_w || round !== hold_r || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold: w=%h round=%0d valid=%b expected w=%h round=%0d valid=1",
                             w, round, out_valid, hold_w, hold_r);
                end
            end
            out_ready = ($urandom_range(99) >= bp_pct);
            if (out_ready) begin
                got_w[idx] = w;
                checks++;
                if (w !== exp_w[idx] || round !== 8'(idx + 1) || last !== (idx == 79)) begin
                    failures++;
                    $display("FAIL word%0d: w=%h round=%0d last=%b expected w=%h round=%0d last=%b",
                             idx, w, round, last, exp_w[idx], idx + 1, idx == 79);
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL run_flags%0d: in_ready=%b busy=%b valid=%b expected 0/1/1",
                             idx, in_ready, busy, out_valid);
                end
                idx++;
                stalled = 1'b0;
            end else begin
                hold_w  = w;
                hold_r  = round;
                stalled = 1'b1;
            end
            tick();
            guard++;
        end
        out_ready = 1'b1;
        if (idx < n_words) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: fired %0d expected %0d", idx, n_words);
        end
        fires = idx;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || round !== 8'd0 ||
            last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: valid=%b in_ready=%b round=%0d last=%b busy=%b expected 0/1/0/0/0",
                     name, out_valid, in_ready, round, last, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset_state");
        checks++;
        if (w !== 32'h0) begin
            failures++;
            $display("FAIL reset_w: got %h expected 00000000", w);
        end
    endtask

    task automatic test_abc();
        logic [511:0] blk;
        int           fires;
        blk = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        start_block(blk);
        drain(80, 0, fires);
        check_idle("abc_end");
        checks++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
            got_w[16] !== 32'hC2C4C700 || got_w[17] !== 32'h00000000 ||
            got_w[18] !== 32'h00000030 || got_w[19] !== 32'h85898E01) begin
            failures++;
            $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h W18=%h W19=%h expected 61626380 00000018 c2c4c700 00000000 00000030 85898e01",
                     got_w[0], got_w[15], got_w[16], got_w[17], got_w[18], got_w[19]);
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] blk;
        int           fires;
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        start_block(blk);
        drain(80, 50, fires);
        checks++;
        if (fires !== 80) begin
            failures++;
            $display("FAIL bp_fires: got %0d expected 80", fires);
        end
        check_idle("bp_end");
    endtask

    task automatic test_back_to_back();
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        int           fires;
        for (int i = 0; i < 16; i++) begin
            blk_a[32*i +: 32] = $urandom;
            blk_b[32*i +: 32] = 32'h1000_0000 * (i + 1) ^ $urandom;
        end
        build_exp(blk_a);
        in_valid = 1'b1;
        block_in = blk_a;
        tick();
        block_in = blk_b;
        drain(80, 0, fires);
        check_idle("b2b_bubble");
        build_exp(blk_b);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || round !== 8'd1 || w !== exp_w[0]) begin
            failures++;
            $display("FAIL b2b_accept: valid=%b round=%0d w=%h expected 1/1/%h",
                     out_valid, round, w, exp_w[0]);
        end
        drain(80, 0, fires);
        check_idle("b2b_end");
    endtask

    task automatic test_ignore_in_valid();
        logic [511:0] blk_a;
        int           fires;
        for (int i = 0; i < 16; i++) blk_a[32*i +: 32] = 32'h0F0F_0000 + 32'(i * 7);
        start_block(blk_a);
        in_valid = 1'b1;
        block_in = {16{32'hDEADBEEF}};
        drain(80, 20, fires);
        in_valid = 1'b0;
        check_idle("ignore_end");
    endtask

    task automatic test_mid_reset();
        logic [511:0] blk;
        int           fires;
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        start_block(blk);
        drain(36, 0, fires);
        checks++;
        if (round !== 8'd37 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: round=%0d valid=%b expected 37/1", round, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_reset");
        checks++;
        if (w !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_w: got %h expected 00000000", w);
        end
        tick();
        check_idle("post_reset_idle");
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        start_block(blk);
        drain(80, 0, fires);
        check_idle("after_reset_end");
    endtask

    task automatic test_all_ones();
        int fires;
        start_block({512{1'b1}});
        drain(80, 0, fires);
        checks++;
        if (got_w[0] !== 32'hFFFFFFFF || got_w[16] !== 32'h00000000) begin
            failures++;
            $display("FAIL ones_known: W0=%h W16=%h expected ffffffff 00000000",
                     got_w[0], got_w[16]);
        end
        check_idle("ones_end");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_ignore_in_valid();
        test_mid_reset();
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
